// File: rtl/mips_pkg.sv
// Shared core-wide constants and types: register-file geometry and the
// writeback entry record used by the result queue.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // Register zero is hardwired; writes to it are dropped and it never forwards.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
        return (addr == ZERO_REG);
    endfunction

endpackage

// File: rtl/writeback_fwd_match.sv
// Forwarding matcher for one decode read port. Entries arrive ordered by age
// (index 0 = oldest); the youngest valid entry whose address matches wins.
module writeback_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]            ent_valid,
    input  logic [DEPTH*REG_ADDR_W-1:0] ent_addr,
    input  logic [DEPTH*DATA_W-1:0]     ent_data,
    input  logic [REG_ADDR_W-1:0]       read_addr,
    output logic                        hit,
    output logic [DATA_W-1:0]           data
);

    logic [DEPTH-1:0]  match_s;
    logic [DATA_W-1:0] fwd_data_s;

    // Per-entry address compare; register zero never matches.
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = ent_valid[i]
                       && (ent_addr[i*REG_ADDR_W +: REG_ADDR_W] == read_addr)
                       && !is_zero_reg(read_addr);
        end
    end

    // Scan oldest to youngest so a younger match overrides an older one.
    always_comb begin
        fwd_data_s = {DATA_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            fwd_data_s = match_s[i] ? ent_data[i*DATA_W +: DATA_W] : fwd_data_s;
        end
    end

    // Drive the port outputs; data stays zero when nothing matches.
    always_comb begin
        hit  = |match_s;
        data = fwd_data_s;
    end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue between the execute results and the register-file
// write port. Holds up to DEPTH pending writes, drains one per cycle unless the
// write port is stalled, and forwards pending values to two decode read ports.
module writeback_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    ResValid,
    output logic                    ResReady,
    input  logic [REG_ADDR_W-1:0]   ResAddr,
    input  logic [DATA_W-1:0]       ResData,
    input  logic                    WriteStall,
    output logic                    RegWrite,
    output logic [REG_ADDR_W-1:0]   WriteAddr,
    output logic [DATA_W-1:0]       WriteData,
    input  logic [REG_ADDR_W-1:0]   ReadAddr1,
    input  logic [REG_ADDR_W-1:0]   ReadAddr2,
    output logic                    FwdHit1,
    output logic                    FwdHit2,
    output logic [DATA_W-1:0]       FwdData1,
    output logic [DATA_W-1:0]       FwdData2,
    output logic [$clog2(DEPTH):0]  Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Entry storage and pointers.
    wb_entry_t          entry_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic                           not_empty_s;
    logic                           res_ready_s;
    logic                           push_s;
    logic                           pop_s;
    logic [DEPTH-1:0]               ord_valid_s;
    logic [DEPTH*REG_ADDR_W-1:0]    ord_addr_s;
    logic [DEPTH*DATA_W-1:0]        ord_data_s;

    // Handshake decode. Ready depends only on occupancy (and is held low while
    // in reset); a stalled write port cannot free a slot in the same cycle.
    always_comb begin
        not_empty_s = (count_r != {CNT_W{1'b0}});
        res_ready_s = Reset && (count_r < DEPTH_C);
        push_s      = ResValid && res_ready_s && !is_zero_reg(ResAddr);
        pop_s       = not_empty_s && !WriteStall;
    end

    // Register-file write port driven from the head entry; zeros when empty.
    always_comb begin
        ResReady = res_ready_s;
        RegWrite = pop_s;
        Count    = count_r;
        if (not_empty_s) begin
            WriteAddr = entry_r[rd_ptr_r].addr;
            WriteData = entry_r[rd_ptr_r].data;
        end else begin
            WriteAddr = {REG_ADDR_W{1'b0}};
            WriteData = {DATA_W{1'b0}};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry payload and valid bits. A push and a pop never target the same slot
    // in one cycle (that would need the queue to be both empty and full).
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '{addr: {REG_ADDR_W{1'b0}}, data: {DATA_W{1'b0}}};
            end
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
            end
            if (push_s) begin
                valid_r[wr_ptr_r]      <= 1'b1;
                entry_r[wr_ptr_r].addr <= ResAddr;
                entry_r[wr_ptr_r].data <= ResData;
            end
        end
    end

    // Re-order the circular buffer by age (index 0 = head/oldest) for the matchers.
    always_comb begin : ord_build
        logic [PTR_W-1:0] slot;
        slot        = {PTR_W{1'b0}};
        ord_valid_s = {DEPTH{1'b0}};
        ord_addr_s  = {(DEPTH*REG_ADDR_W){1'b0}};
        ord_data_s  = {(DEPTH*DATA_W){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr_r + PTR_W'(i);
            ord_valid_s[i]                         = valid_r[slot];
            ord_addr_s[i*REG_ADDR_W +: REG_ADDR_W] = entry_r[slot].addr;
            ord_data_s[i*DATA_W +: DATA_W]         = entry_r[slot].data;
        end
    end

    writeback_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
        .ent_valid (ord_valid_s),
        .ent_addr  (ord_addr_s),
        .ent_data  (ord_data_s),
        .read_addr (ReadAddr1),
        .hit       (FwdHit1),
        .data      (FwdData1)
    );

    writeback_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
        .ent_valid (ord_valid_s),
        .ent_addr  (ord_addr_s),
        .ent_data  (ord_data_s),
        .read_addr (ReadAddr2),
        .hit       (FwdHit2),
        .data      (FwdData2)
    );

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed vectors, with expected register-file
// writes queued at acceptance and checked by an independent write-port monitor.
module tb_writeback_queue;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        ResValid;
    logic        ResReady;
    logic [4:0]  ResAddr;
    logic [31:0] ResData;
    logic        WriteStall;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [4:0]  ReadAddr1;
    logic [4:0]  ReadAddr2;
    logic        FwdHit1;
    logic        FwdHit2;
    logic [31:0] FwdData1;
    logic [31:0] FwdData2;
    logic [2:0]  Count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors         = 0;
    int   miscompares     = 0;
    int   writes_seen     = 0;
    int   writes_expected = 0;

    writeback_queue #(.DEPTH(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .ResValid   (ResValid),
        .ResReady   (ResReady),
        .ResAddr    (ResAddr),
        .ResData    (ResData),
        .WriteStall (WriteStall),
        .RegWrite   (RegWrite),
        .WriteAddr  (WriteAddr),
        .WriteData  (WriteData),
        .ReadAddr1  (ReadAddr1),
        .ReadAddr2  (ReadAddr2),
        .FwdHit1    (FwdHit1),
        .FwdHit2    (FwdHit2),
        .FwdData1   (FwdData1),
        .FwdData2   (FwdData2),
        .Count      (Count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Write-port monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge Clock) begin
        if (RegWrite === 1'b1) begin
            writes_seen++;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         WriteAddr, WriteData);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", {27'd0, WriteAddr}, {27'd0, mon_e.addr});
                check("write_data", WriteData, mon_e.data);
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Offer one result and hold it until the handshake completes (bounded).
    task automatic offer(input logic [4:0] ad, input logic [31:0] dd);
        logic ok;
        ok       = 1'b0;
        ResValid = 1'b1;
        ResAddr  = ad;
        ResData  = dd;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge Clock);
            ok = ResReady;
            @(posedge Clock);
            if (ok && ad != 5'd0) begin
                exp_q.push_back('{addr: ad, data: dd});
                writes_expected++;
            end
            #1;
        end
        ResValid = 1'b0;
        ResAddr  = 5'd0;
        ResData  = 32'd0;
        check("offer_accepted", {31'd0, ok}, 32'd1);
    endtask

    // Wait (bounded) until every expected write has been observed, then expect empty.
    task automatic drain(input string name);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            tick();
        end
        @(negedge Clock);
        check(name, exp_q.size(), 32'd0);
        check({name, "_count"}, {29'd0, Count}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset      = 1'b0;
        ResValid   = 1'b0;
        ResAddr    = 5'd0;
        ResData    = 32'd0;
        WriteStall = 1'b0;
        ReadAddr1  = 5'd0;
        ReadAddr2  = 5'd0;

        // Reset state
        #2;
        check("rst_ready",     {31'd0, ResReady}, 32'd0);
        check("rst_count",     {29'd0, Count}, 32'd0);
        check("rst_regwrite",  {31'd0, RegWrite}, 32'd0);
        check("rst_waddr",     {27'd0, WriteAddr}, 32'd0);
        check("rst_wdata",     WriteData, 32'd0);
        check("rst_fwdhit1",   {31'd0, FwdHit1}, 32'd0);
        check("rst_fwdhit2",   {31'd0, FwdHit2}, 32'd0);
        check("rst_fwddata1",  FwdData1, 32'd0);
        check("rst_fwddata2",  FwdData2, 32'd0);
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b1;
        @(negedge Clock);
        check("post_rst_ready", {31'd0, ResReady}, 32'd1);
        check("post_rst_count", {29'd0, Count}, 32'd0);

        // Single write, no bypass from the result input
        tick();
        ReadAddr1 = 5'd5;
        ResValid  = 1'b1;
        ResAddr   = 5'd5;
        ResData   = 32'hDEADBEEF;
        @(negedge Clock);
        check("single_no_fwd_bypass", {31'd0, FwdHit1}, 32'd0);
        check("single_no_wr_bypass",  {31'd0, RegWrite}, 32'd0);
        @(posedge Clock);
        exp_q.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        writes_expected++;
        #1;
        ResValid = 1'b0;
        @(negedge Clock);
        check("single_regwrite", {31'd0, RegWrite}, 32'd1);
        check("single_waddr",    {27'd0, WriteAddr}, 32'd5);
        check("single_wdata",    WriteData, 32'hDEADBEEF);
        check("single_fwdhit",   {31'd0, FwdHit1}, 32'd1);
        check("single_fwddata",  FwdData1, 32'hDEADBEEF);
        check("single_count1",   {29'd0, Count}, 32'd1);
        tick();
        @(negedge Clock);
        check("single_count0",   {29'd0, Count}, 32'd0);
        check("single_idle",     {31'd0, RegWrite}, 32'd0);
        ReadAddr1 = 5'd0;

        // Fill and backpressure
        tick();
        WriteStall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(5'(i), 32'hA0 + 32'(i));
        end
        @(negedge Clock);
        check("fill_count",  {29'd0, Count}, 32'd4);
        check("fill_ready",  {31'd0, ResReady}, 32'd0);
        tick();
        ResValid = 1'b1;
        ResAddr  = 5'd5;
        ResData  = 32'hA5;
        tick();
        tick();
        @(negedge Clock);
        check("hold_count",    {29'd0, Count}, 32'd4);
        check("hold_ready",    {31'd0, ResReady}, 32'd0);
        check("hold_regwrite", {31'd0, RegWrite}, 32'd0);
        tick();
        WriteStall = 1'b0;
        offer(5'd5, 32'hA5);
        drain("fill_drain");

        // Zero register discard
        tick();
        ReadAddr1 = 5'd0;
        offer(5'd0, 32'h1234);
        @(negedge Clock);
        check("zero_count",  {29'd0, Count}, 32'd0);
        check("zero_fwdhit", {31'd0, FwdHit1}, 32'd0);
        repeat (3) tick();

        // Forwarding priority, including the head being written
        WriteStall = 1'b1;
        offer(5'd7, 32'h11);
        offer(5'd7, 32'h22);
        offer(5'd3, 32'h33);
        ReadAddr1 = 5'd7;
        ReadAddr2 = 5'd3;
        @(negedge Clock);
        check("fwd_count",  {29'd0, Count}, 32'd3);
        check("fwd_hit1",   {31'd0, FwdHit1}, 32'd1);
        check("fwd_data1",  FwdData1, 32'h22);
        check("fwd_hit2",   {31'd0, FwdHit2}, 32'd1);
        check("fwd_data2",  FwdData2, 32'h33);
        tick();
        WriteStall = 1'b0;
        @(negedge Clock);
        check("fwd_head_hit1",  {31'd0, FwdHit1}, 32'd1);
        check("fwd_head_data1", FwdData1, 32'h22);
        tick();
        @(negedge Clock);
        check("fwd_after1_hit1",  {31'd0, FwdHit1}, 32'd1);
        check("fwd_after1_data1", FwdData1, 32'h22);
        tick();
        @(negedge Clock);
        check("fwd_after2_hit1",  {31'd0, FwdHit1}, 32'd0);
        check("fwd_after2_data1", FwdData1, 32'd0);
        check("fwd_after2_hit2",  {31'd0, FwdHit2}, 32'd1);
        check("fwd_after2_data2", FwdData2, 32'h33);
        drain("fwd_drain");
        ReadAddr1 = 5'd0;
        ReadAddr2 = 5'd0;

        // Wrap with a push every cycle and the write port free
        tick();
        for (int i = 0; i < 10; i++) begin
            ResValid = 1'b1;
            ResAddr  = 5'(i + 1);
            ResData  = 32'h100 + 32'(i);
            @(negedge Clock);
            check("wrap_count_le1", {31'd0, (Count <= 3'd1)}, 32'd1);
            check("wrap_ready",     {31'd0, ResReady}, 32'd1);
            @(posedge Clock);
            exp_q.push_back('{addr: 5'(i + 1), data: 32'h100 + 32'(i)});
            writes_expected++;
            #1;
        end
        ResValid = 1'b0;
        drain("wrap_drain");

        // Reset in the middle of operation drops pending entries
        tick();
        WriteStall = 1'b1;
        offer(5'd10, 32'hC10);
        offer(5'd11, 32'hC11);
        offer(5'd12, 32'hC12);
        ReadAddr1 = 5'd11;
        @(negedge Clock);
        check("mid_count3", {29'd0, Count}, 32'd3);
        check("mid_hit",    {31'd0, FwdHit1}, 32'd1);
        tick();
        Reset      = 1'b0;
        WriteStall = 1'b0;
        writes_expected -= exp_q.size();
        exp_q.delete();
        #1;
        check("mid_rst_regwrite", {31'd0, RegWrite}, 32'd0);
        check("mid_rst_count",    {29'd0, Count}, 32'd0);
        check("mid_rst_fwdhit",   {31'd0, FwdHit1}, 32'd0);
        check("mid_rst_fwddata",  FwdData1, 32'd0);
        check("mid_rst_waddr",    {27'd0, WriteAddr}, 32'd0);
        check("mid_rst_ready",    {31'd0, ResReady}, 32'd0);
        repeat (2) tick();
        Reset = 1'b1;
        repeat (6) tick();
        @(negedge Clock);
        check("after_rst_ready", {31'd0, ResReady}, 32'd1);
        check("after_rst_count", {29'd0, Count}, 32'd0);
        ReadAddr1 = 5'd0;
        tick();
        offer(5'd20, 32'hABC);
        drain("after_rst_drain");

        check("total_writes", writes_seen, writes_expected);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
